// File: rtl/b_pipe_pkg.sv
// Shared constants for the B-operand input pipeline.
package b_pipe_pkg;

    localparam logic        SEL_DIRECT  = 1'b0;
    localparam logic        SEL_CASCADE = 1'b1;
    localparam int unsigned MAX_DEPTH   = 4;
    localparam int unsigned OCC_W       = 3;

endpackage

// File: rtl/pipe_stage.sv
// One operand register plus its valid bit; FLUSH wins over CE, RSTB clears asynchronously.
module pipe_stage #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             VLD_D,
    output logic [WIDTH-1:0] Q,
    output logic             VLD_Q
);

    // Data and valid advance together; invalid slots still carry data.
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            Q     <= '0;
            VLD_Q <= 1'b0;
        end else if (FLUSH) begin
            Q     <= '0;
            VLD_Q <= 1'b0;
        end else if (CE) begin
            Q     <= D;
            VLD_Q <= VLD_D;
        end
    end

endmodule

// File: rtl/b_input_pipe.sv
// B-operand input pipeline: direct/cascade select followed by DEPTH register stages
// with per-slot valid bits and a running occupancy count.
module b_input_pipe
    import b_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic             SEL,
    input  logic [WIDTH-1:0] BIN,
    input  logic [WIDTH-1:0] BCIN,
    input  logic             VLD_IN,
    output logic [WIDTH-1:0] BOUT,
    output logic [WIDTH-1:0] BCOUT,
    output logic             VLD_OUT,
    output logic [OCC_W-1:0] OCC
);

    logic [WIDTH-1:0] sel_operand;

    // Source mux, sampled in the same cycle as the data it selects.
    assign sel_operand = (SEL == SEL_CASCADE) ? BCIN : BIN;

    if (DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("b_input_pipe: DEPTH %0d exceeds MAX_DEPTH %0d", DEPTH, MAX_DEPTH);
    end

    if (DEPTH == 0) begin : g_comb
        logic unused_ctrl;

        // Zero-depth build is a pure wire path; clock-side controls are unused.
        assign unused_ctrl = ^{CLK, RSTB, CE, FLUSH};
        assign BOUT        = sel_operand;
        assign BCOUT       = sel_operand;
        assign VLD_OUT     = VLD_IN;
        assign OCC         = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] chain_d [DEPTH+1];
        logic [DEPTH:0]   chain_v;
        logic [OCC_W-1:0] occ_q;

        assign chain_d[0] = sel_operand;
        assign chain_v[0] = VLD_IN;

        for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .CLK   (CLK),
                .RSTB  (RSTB),
                .CE    (CE),
                .FLUSH (FLUSH),
                .D     (chain_d[k]),
                .VLD_D (chain_v[k]),
                .Q     (chain_d[k+1]),
                .VLD_Q (chain_v[k+1])
            );
        end

        // Occupancy tracks valid bits entering stage 0 and leaving the last stage.
        always_ff @(posedge CLK or posedge RSTB) begin
            if (RSTB) begin
                occ_q <= '0;
            end else if (FLUSH) begin
                occ_q <= '0;
            end else if (CE) begin
                occ_q <= occ_q + OCC_W'(VLD_IN) - OCC_W'(chain_v[DEPTH]);
            end
        end

        assign BOUT    = chain_d[DEPTH];
        assign BCOUT   = chain_d[DEPTH];
        assign VLD_OUT = chain_v[DEPTH];
        assign OCC     = occ_q;
    end

endmodule

// File: tb/tb_b_input_pipe.sv
// Self-checking bench for b_input_pipe at DEPTH 0, 2 and 3 against a queue model.
module tb_b_input_pipe;

    localparam int unsigned W = 18;

    logic         CLK = 1'b0;
    logic         RSTB = 1'b0;
    logic         CE = 1'b0;
    logic         FLUSH = 1'b0;
    logic         SEL = 1'b0;
    logic [W-1:0] BIN = '0;
    logic [W-1:0] BCIN = '0;
    logic         VLD_IN = 1'b0;

    logic [W-1:0] bout0, bcout0, bout2, bcout2, bout3, bcout3;
    logic         vo0, vo2, vo3;
    logic [2:0]   occ0, occ2, occ3;

    int checks = 0;
    int errors = 0;

    // Model: queue front = newest slot, back = slot presented at the output.
    logic [W-1:0] q2_d[$];
    logic [W-1:0] q3_d[$];
    bit           q2_v[$];
    bit           q3_v[$];

    always #5 CLK = ~CLK;

    b_input_pipe #(.WIDTH(W), .DEPTH(0)) u_d0 (
        .CLK(CLK), .RSTB(RSTB), .CE(CE), .FLUSH(FLUSH), .SEL(SEL), .BIN(BIN), .BCIN(BCIN),
        .VLD_IN(VLD_IN), .BOUT(bout0), .BCOUT(bcout0), .VLD_OUT(vo0), .OCC(occ0));
    b_input_pipe #(.WIDTH(W), .DEPTH(2)) u_d2 (
        .CLK(CLK), .RSTB(RSTB), .CE(CE), .FLUSH(FLUSH), .SEL(SEL), .BIN(BIN), .BCIN(BCIN),
        .VLD_IN(VLD_IN), .BOUT(bout2), .BCOUT(bcout2), .VLD_OUT(vo2), .OCC(occ2));
    b_input_pipe #(.WIDTH(W), .DEPTH(3)) u_d3 (
        .CLK(CLK), .RSTB(RSTB), .CE(CE), .FLUSH(FLUSH), .SEL(SEL), .BIN(BIN), .BCIN(BCIN),
        .VLD_IN(VLD_IN), .BOUT(bout3), .BCOUT(bcout3), .VLD_OUT(vo3), .OCC(occ3));

    function automatic logic [W-1:0] sel_val();
        return SEL ? BCIN : BIN;
    endfunction

    function automatic int occ2_model();
        int n = 0;
        foreach (q2_v[i]) n += int'(q2_v[i]);
        return n;
    endfunction

    function automatic int occ3_model();
        int n = 0;
        foreach (q3_v[i]) n += int'(q3_v[i]);
        return n;
    endfunction

    task automatic model_clear();
        q2_d = {}; q2_v = {}; q3_d = {}; q3_v = {};
        for (int i = 0; i < 2; i++) begin q2_d.push_back('0); q2_v.push_back(1'b0); end
        for (int i = 0; i < 3; i++) begin q3_d.push_back('0); q3_v.push_back(1'b0); end
    endtask

    task automatic model_edge();
        if (FLUSH) begin
            model_clear();
        end else if (CE) begin
            q2_d.push_front(sel_val()); q2_v.push_front(VLD_IN);
            q3_d.push_front(sel_val()); q3_v.push_front(VLD_IN);
            void'(q2_d.pop_back()); void'(q2_v.pop_back());
            void'(q3_d.pop_back()); void'(q3_v.pop_back());
        end
    endtask

    task automatic clk_edge();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_flush();
        FLUSH = 1'b1;
        clk_edge();
        FLUSH = 1'b0;
    endtask

    task automatic test_reset();
        #1 RSTB = 1'b1;
        model_clear();
        CE = 1'b1; SEL = 1'b0; BIN = 18'h00155; BCIN = 18'h2AAAA; VLD_IN = 1'b1;
        #13;
        checks++;
        if (bout2 !== '0 || bcout2 !== '0 || vo2 !== 1'b0 || occ2 !== 3'd0) begin
            errors++;
            $display("FAIL reset_d2: bout=%h bcout=%h vld=%b occ=%0d, want 0 0 0 0", bout2, bcout2, vo2, occ2);
        end
        checks++;
        if (bout3 !== '0 || vo3 !== 1'b0 || occ3 !== 3'd0) begin
            errors++;
            $display("FAIL reset_d3: bout=%h vld=%b occ=%0d, want 0 0 0", bout3, vo3, occ3);
        end
        checks++;
        if (bout0 !== 18'h00155 || vo0 !== 1'b1 || occ0 !== 3'd0) begin
            errors++;
            $display("FAIL reset_d0: bout=%h vld=%b occ=%0d, want 00155 1 0", bout0, vo0, occ0);
        end
        @(negedge CLK);
        RSTB = 1'b0;
    endtask

    task automatic test_basic();
        do_flush();
        SEL = 1'b0; CE = 1'b1; VLD_IN = 1'b1; BCIN = 18'h3C3C3;
        BIN = 18'h00011;
        clk_edge();
        checks++;
        if (occ2 !== 3'd1 || vo2 !== 1'b0) begin
            errors++;
            $display("FAIL basic_first: occ=%0d vld=%b, want 1 0", occ2, vo2);
        end
        BIN = 18'h00022;
        clk_edge();
        checks++;
        if (bout2 !== 18'h00011 || bcout2 !== 18'h00011 || vo2 !== 1'b1 || occ2 !== 3'd2) begin
            errors++;
            $display("FAIL basic_latency: bout=%h bcout=%h vld=%b occ=%0d, want 00011 00011 1 2",
                     bout2, bcout2, vo2, occ2);
        end
    endtask

    task automatic test_ce_hold();
        logic ce_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] want;
        do_flush();
        SEL = 1'b1; BCIN = 18'h3FFFF; BIN = 18'h01234; VLD_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CE = ce_seq[i];
            clk_edge();
            want = (i == 3) ? 18'h3FFFF : 18'h00000;
            checks++;
            if (bout2 !== want || vo2 !== (i == 3)) begin
                errors++;
                $display("FAIL ce_hold edge %0d: bout=%h vld=%b, want %h %b", i, bout2, vo2, want, i == 3);
            end
        end
    endtask

    task automatic test_flush();
        do_flush();
        CE = 1'b1; VLD_IN = 1'b1; SEL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BIN = W'($urandom);
            clk_edge();
        end
        checks++;
        if (occ3 !== 3'd3 || vo3 !== 1'b1 || bout3 !== q3_d[$]) begin
            errors++;
            $display("FAIL flush_full: occ=%0d vld=%b bout=%h, want 3 1 %h", occ3, vo3, bout3, q3_d[$]);
        end
        CE = 1'b0; FLUSH = 1'b1;
        clk_edge();
        FLUSH = 1'b0;
        checks++;
        if (bout3 !== '0 || vo3 !== 1'b0 || occ3 !== 3'd0 || occ2 !== 3'd0) begin
            errors++;
            $display("FAIL flush_clear: bout=%h vld=%b occ3=%0d occ2=%0d, want 0 0 0 0", bout3, vo3, occ3, occ2);
        end
    endtask

    task automatic test_async_reset();
        CE = 1'b1; VLD_IN = 1'b1; SEL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BIN = W'($urandom) | 18'h00001;
            clk_edge();
        end
        #2 RSTB = 1'b1;
        model_clear();
        #1;
        checks++;
        if (bout2 !== '0 || vo2 !== 1'b0 || occ2 !== 3'd0 || bout3 !== '0 || occ3 !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: bout2=%h vld2=%b occ2=%0d bout3=%h occ3=%0d, want all 0",
                     bout2, vo2, occ2, bout3, occ3);
        end
        @(negedge CLK);
        RSTB = 1'b0;
    endtask

    task automatic test_valid_pattern();
        logic vpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic want_v;
        do_flush();
        CE = 1'b1; SEL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            VLD_IN = vpat[i];
            BIN = W'($urandom);
            clk_edge();
            want_v = (i >= 1) ? vpat[i-1] : 1'b0;
            if (i >= 2) want_v = vpat[i-1];
            want_v = (i >= 1) ? vpat[i-1] : 1'b0;
            checks++;
            if (vo2 !== q2_v[$] || occ2 !== 3'(occ2_model()) || (i >= 1 && vo2 !== vpat[i-1])) begin
                errors++;
                $display("FAIL valid_pattern edge %0d: vld=%b occ=%0d, want %b %0d",
                         i, vo2, occ2, want_v, occ2_model());
            end
        end
    endtask

    task automatic test_depth0();
        SEL = 1'b0; BIN = 18'h12345; BCIN = 18'h0ABCD; VLD_IN = 1'b1;
        #1;
        checks++;
        if (bout0 !== 18'h12345 || bcout0 !== 18'h12345 || vo0 !== 1'b1 || occ0 !== 3'd0) begin
            errors++;
            $display("FAIL depth0_direct: bout=%h bcout=%h vld=%b occ=%0d, want 12345 12345 1 0",
                     bout0, bcout0, vo0, occ0);
        end
        SEL = 1'b1; VLD_IN = 1'b0;
        #1;
        checks++;
        if (bout0 !== 18'h0ABCD || bcout0 !== 18'h0ABCD || vo0 !== 1'b0) begin
            errors++;
            $display("FAIL depth0_cascade: bout=%h bcout=%h vld=%b, want 0abcd 0abcd 0", bout0, bcout0, vo0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            SEL    = 1'($urandom);
            BIN    = W'($urandom);
            BCIN   = W'($urandom);
            VLD_IN = 1'($urandom);
            CE     = ($urandom_range(0, 3) != 0);
            FLUSH  = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (bout0 !== sel_val() || bcout0 !== sel_val() || vo0 !== VLD_IN || occ0 !== 3'd0) begin
                errors++;
                $display("FAIL rand_d0 cyc %0d: bout=%h vld=%b occ=%0d, want %h %b 0",
                         c, bout0, vo0, occ0, sel_val(), VLD_IN);
            end
            clk_edge();
            checks++;
            if (bout2 !== q2_d[$] || bcout2 !== q2_d[$] || vo2 !== q2_v[$] || occ2 !== 3'(occ2_model())) begin
                errors++;
                $display("FAIL rand_d2 cyc %0d: bout=%h bcout=%h vld=%b occ=%0d, want %h %b %0d",
                         c, bout2, bcout2, vo2, occ2, q2_d[$], q2_v[$], occ2_model());
            end
            checks++;
            if (bout3 !== q3_d[$] || bcout3 !== q3_d[$] || vo3 !== q3_v[$] || occ3 !== 3'(occ3_model())) begin
                errors++;
                $display("FAIL rand_d3 cyc %0d: bout=%h bcout=%h vld=%b occ=%0d, want %h %b %0d",
                         c, bout3, bcout3, vo3, occ3, q3_d[$], q3_v[$], occ3_model());
            end
        end
        FLUSH = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ce_hold();
        test_flush();
        test_async_reset();
        test_valid_pattern();
        test_depth0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
